// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and output-stage state shared by alu and alu_arbiter.
package alu_pkg;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_EQUAL = 4'b0110;
    localparam logic [3:0] OP_LESS  = 4'b1100;
    typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational AND/ADD/EQUAL/unsigned-LESS unit; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca_i,
    input  logic [DATA_WIDTH-1:0]    srcb_i,
    input  logic [OPCODE_LENGTH-1:0] op_i,
    output logic [DATA_WIDTH-1:0]    result_o
);
    always_comb
        result_o = op_i == OPCODE_LENGTH'(OP_AND)   ? srca_i & srcb_i :
                   op_i == OPCODE_LENGTH'(OP_ADD)   ? srca_i + srcb_i :
                   op_i == OPCODE_LENGTH'(OP_EQUAL) ? DATA_WIDTH'(srca_i == srcb_i) :
                   op_i == OPCODE_LENGTH'(OP_LESS)  ? DATA_WIDTH'(srca_i < srcb_i) : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter for two requesters sharing one ALU,
// feeding a single-entry result register that refills in the cycle it drains.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0][DATA_WIDTH-1:0]    req_srca,
    input  logic [1:0][DATA_WIDTH-1:0]    req_srcb,
    input  logic [1:0][OPCODE_LENGTH-1:0] req_op,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data
);
    state_e state_q, state_d;
    logic last_q, last_d, id_q, id_d, sel, xfer;
    logic [1:0] grant;
    logic [DATA_WIDTH-1:0] data_q, data_d, alu_res;

    alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
        .srca_i  (req_srca[sel]),
        .srcb_i  (req_srcb[sel]),
        .op_i    (req_op[sel]),
        .result_o(alu_res)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = req_valid == 2'b11 ? (last_q ? 2'b01 : 2'b10) : req_valid;
        sel = grant[1];
        req_ready = (!reset && (state_q == EMPTY || rsp_ready)) ? grant : 2'b00;
        xfer = |req_ready;
        state_d = xfer ? FULL : rsp_ready ? EMPTY : state_q;
        last_d = xfer ? sel : last_q;
        id_d = xfer ? sel : id_q;
        data_d = xfer ? alu_res : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            last_q <= 1'b1;
            id_q <= 1'b0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            id_q <= id_d;
            data_q <= data_d;
        end
    end

    assign rsp_valid = state_q == FULL;
    assign rsp_id = id_q;
    assign rsp_data = data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    logic clk, reset, rsp_valid, rsp_ready, rsp_id;
    logic [1:0] req_valid, req_ready;
    logic [1:0][31:0] req_srca, req_srcb;
    logic [1:0][3:0] req_op;
    logic [31:0] rsp_data;
    int tests = 0, fails = 0;
    bit m_full, m_id, m_last;
    logic [31:0] m_data;

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        longint unsigned s;
        s = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
        case (op)
            4'd0:  return a & b;
            4'd2:  return s[31:0];
            4'd6:  return (a == b) ? 32'd1 : 32'd0;
            4'd12: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs driven: compares outputs, then advances the model one clock.
    task automatic cycle();
        logic [1:0] er;
        int p;
        #1;
        p = (req_valid == 2'b10 || (req_valid == 2'b11 && !m_last)) ? 1 : 0;
        er = (reset || req_valid == 2'b00 || (m_full && !rsp_ready)) ? 2'b00 : (p == 1 ? 2'b10 : 2'b01);
        chk("req_ready", {30'd0, req_ready}, {30'd0, er});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        @(posedge clk);
        if (reset) begin
            m_full = 0; m_data = 0; m_id = 0; m_last = 1;
        end else if (er != 2'b00) begin
            m_full = 1; m_data = ref_alu(req_srca[p], req_srcb[p], req_op[p]);
            m_id = p[0]; m_last = p[0];
        end else if (rsp_ready) m_full = 0;
        @(negedge clk);
    endtask

    logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd9, 32'hF0};
    logic [31:0] tb [5] = '{32'd1, 32'd3, 32'h8000_0000, 32'd9, 32'h3C};
    logic [3:0]  to [5] = '{4'b0010, 4'b0110, 4'b1100, 4'b1111, 4'b0000};
    logic [31:0] te [5] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'h30};
    logic [3:0]  opset [4] = '{4'd0, 4'd2, 4'd6, 4'd12};

    initial begin
        m_full = 0; m_data = 0; m_id = 0; m_last = 1;
        reset = 1; rsp_ready = 0; req_valid = 2'b11;
        req_srca = '0; req_srcb = '0; req_op = '0;
        @(negedge clk);
        cycle(); cycle();
        // Single request after reset: 5 + 7.
        reset = 0; rsp_ready = 1; req_valid = 2'b01;
        req_srca[0] = 5; req_srcb[0] = 7; req_op[0] = 4'b0010;
        #1 chk("lit_ready_single", {30'd0, req_ready}, 32'd1);
        cycle();
        req_valid = 2'b00;
        #1 chk("lit_add_data", rsp_data, 32'd12);
        chk("lit_add_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lit_add_id", {31'd0, rsp_id}, 32'd0);
        cycle();
        // Both requesting from reset alternates 0,1,0,1 with no bubble.
        reset = 1; cycle(); reset = 0;
        req_srca[1] = 32'hF0; req_srcb[1] = 32'h3C; req_op[1] = 4'b0000;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("lit_rr_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) begin
                chk("lit_rr_id", {31'd0, rsp_id}, ((i - 1) % 2 == 0) ? 32'd0 : 32'd1);
                chk("lit_rr_data", rsp_data, ((i - 1) % 2 == 0) ? 32'd12 : 32'h30);
            end
            cycle();
        end
        // Stall while FULL with requester 1 waiting.
        rsp_ready = 0; req_valid = 2'b10;
        req_srca[1] = 3; req_srcb[1] = 3; req_op[1] = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit_stall_ready", {30'd0, req_ready}, 32'd0);
            chk("lit_stall_data", rsp_data, 32'h30);
            chk("lit_stall_id", {31'd0, rsp_id}, 32'd1);
            cycle();
        end
        rsp_ready = 1;
        #1 chk("lit_unstall_ready", {30'd0, req_ready}, 32'd2);
        cycle();
        req_valid = 2'b00;
        #1 chk("lit_unstall_data", rsp_data, 32'd1);
        chk("lit_unstall_id", {31'd0, rsp_id}, 32'd1);
        cycle();
        // Opcode corner cases, back to back through requester 0.
        for (int i = 0; i < 5; i++) begin
            req_valid = 2'b01;
            req_srca[0] = ta[i]; req_srcb[0] = tb[i]; req_op[0] = to[i];
            #1 if (i > 0) chk("lit_op", rsp_data, te[i-1]);
            cycle();
        end
        req_valid = 2'b00;
        #1 chk("lit_op", rsp_data, te[4]);
        // Reset while FULL and stalled discards the result.
        rsp_ready = 0; reset = 1;
        cycle();
        reset = 0;
        #1 chk("lit_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lit_rst_data", rsp_data, 32'd0);
        chk("lit_rst_id", {31'd0, rsp_id}, 32'd0);
        rsp_ready = 1; req_valid = 2'b11;
        #1 chk("lit_rst_tie", {30'd0, req_ready}, 32'd1);
        cycle();
        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 60) == 0);
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                req_op[r] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : opset[$urandom_range(0, 3)];
                req_srca[r] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                req_srcb[r] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            end
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
